// File: rtl/weight_sram_arbiter.sv
// weight_sram_arbiter: shares one Weight SRAM port between PU_NUM round-robin readers and a priority writer.
//   clock, reset (async, active-low)
//   rd_req/rd_addr -> rd_ready/rd_data : per-PU read requests, one-cycle ready pulse with registered data
//   wr_req/wr_addr -> wr_ack           : loader write request, one-cycle ack pulse
//   sram_addr/sram_r_en/sram_w_en      : registered SRAM controller command
//   sram_r_d/sram_d_ready/sram_w_done  : SRAM controller response
//   WEIGHT_ARB_STATS_EN adds stat_rd_cnt (completed reads) and stat_wait_cnt (cycles readers wait), saturating
module weight_sram_arbiter #(
  parameter int PU_NUM = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PU_NUM-1:0]        rd_req,
  input  logic [PU_NUM*ADDR_W-1:0] rd_addr,
  output logic [PU_NUM-1:0]        rd_ready,
  output logic [DATA_W-1:0]        rd_data,
  input  logic                     wr_req,
  input  logic [ADDR_W-1:0]        wr_addr,
  output logic                     wr_ack,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic                     sram_r_en,
  output logic                     sram_w_en,
  input  logic [DATA_W-1:0]        sram_r_d,
  input  logic                     sram_d_ready,
  input  logic                     sram_w_done
`ifdef WEIGHT_ARB_STATS_EN
  ,
  output logic [31:0]              stat_rd_cnt,
  output logic [31:0]              stat_wait_cnt
`endif
);
  localparam int PW = $clog2(PU_NUM);
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, g_q, g_d, pick;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d, pick_addr;
  logic sram_r_en_q, sram_r_en_d, sram_w_en_q, sram_w_en_d, wr_ack_q, wr_ack_d, wr_pend;
  logic [PU_NUM-1:0] rd_ready_q, rd_ready_d, rd_pend;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // A requester still sees its request high during its ready/ack cycle; that level is not a new request.
  always_comb begin
    rd_pend = rd_req & ~rd_ready_q;
    wr_pend = wr_req & ~wr_ack_q;
    pick = '0;
    for (int i = PU_NUM-1; i >= 0; i--) if (rd_pend[i]) pick = PW'(i);
    for (int i = PU_NUM-1; i >= 0; i--) if (rd_pend[i] && PW'(i) >= rr_ptr_q) pick = PW'(i);
    pick_addr = '0;
    for (int i = 0; i < PU_NUM; i++) if (pick == PW'(i)) pick_addr = rd_addr[i*ADDR_W +: ADDR_W];
  end

  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    g_d = g_q;
    sram_addr_d = sram_addr_q;
    sram_r_en_d = sram_r_en_q;
    sram_w_en_d = sram_w_en_q;
    rd_ready_d = '0;
    rd_data_d = rd_data_q;
    wr_ack_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_pend) begin
          state_d = WRITE;
          sram_w_en_d = 1'b1;
          sram_addr_d = wr_addr;
        end else if (|rd_pend) begin
          state_d = READ;
          sram_r_en_d = 1'b1;
          sram_addr_d = pick_addr;
          g_d = pick;
        end
      end
      WRITE: if (sram_w_done) begin
        state_d = IDLE;
        sram_w_en_d = 1'b0;
        wr_ack_d = 1'b1;
      end
      READ: if (sram_d_ready) begin
        state_d = RESP;
        sram_r_en_d = 1'b0;
        rd_data_d = sram_r_d;
      end
      RESP: begin
        state_d = IDLE;
        for (int i = 0; i < PU_NUM; i++) rd_ready_d[i] = (g_q == PW'(i));
        rr_ptr_d = (g_q == PW'(PU_NUM-1)) ? '0 : g_q + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      g_q <= '0;
      sram_addr_q <= '0;
      sram_r_en_q <= 1'b0;
      sram_w_en_q <= 1'b0;
      rd_ready_q <= '0;
      rd_data_q <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      g_q <= g_d;
      sram_addr_q <= sram_addr_d;
      sram_r_en_q <= sram_r_en_d;
      sram_w_en_q <= sram_w_en_d;
      rd_ready_q <= rd_ready_d;
      rd_data_q <= rd_data_d;
      wr_ack_q <= wr_ack_d;
    end
  end

  assign rd_ready = rd_ready_q;
  assign rd_data = rd_data_q;
  assign wr_ack = wr_ack_q;
  assign sram_addr = sram_addr_q;
  assign sram_r_en = sram_r_en_q;
  assign sram_w_en = sram_w_en_q;

`ifdef WEIGHT_ARB_STATS_EN
  logic [31:0] stat_rd_cnt_q, stat_rd_cnt_d, stat_wait_cnt_q, stat_wait_cnt_d;

  // Reads count as the ready pulse is launched, so the count matches the visible rd_ready.
  always_comb begin
    stat_rd_cnt_d = stat_rd_cnt_q + 32'((state_q == RESP) && (stat_rd_cnt_q != '1));
    stat_wait_cnt_d = stat_wait_cnt_q + 32'((|rd_req) && (rd_ready_q == '0) && (stat_wait_cnt_q != '1));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_rd_cnt_q <= '0;
      stat_wait_cnt_q <= '0;
    end else begin
      stat_rd_cnt_q <= stat_rd_cnt_d;
      stat_wait_cnt_q <= stat_wait_cnt_d;
    end
  end

  assign stat_rd_cnt = stat_rd_cnt_q;
  assign stat_wait_cnt = stat_wait_cnt_q;
`endif
endmodule
